// File: rtl/hs_npu_mm_stream_ctrl.sv
// Self-sequencing skew/deskew controller for the NPU matrix-multiply datapath.
// Skews accepted input vectors into the array and re-aligns the skewed results.
module hs_npu_mm_stream_ctrl #(
  parameter int unsigned ROWS          = 8,
  parameter int unsigned COLS          = 8,
  parameter int unsigned IN_W          = 16,
  parameter int unsigned OUT_W         = 32,
  parameter int unsigned ARRAY_LATENCY = 8,
  parameter int unsigned CNT_W         = 16
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start_i,
  input  logic                  abort_i,
  input  logic [CNT_W-1:0]      num_vectors_i,
  input  logic [ROWS*IN_W-1:0]  in_data_i,
  input  logic                  in_valid_i,
  output logic                  in_ready_o,
  output logic [ROWS*IN_W-1:0]  a_o,
  output logic [ROWS-1:0]       a_valid_o,
  input  logic [COLS*OUT_W-1:0] res_i,
  output logic [COLS*OUT_W-1:0] out_data_o,
  output logic                  out_valid_o,
  output logic                  busy_o,
  output logic                  done_o
);

  // Accept tag reaches the output register after ARRAY_LATENCY+COLS+1 cycles in total.
  localparam int unsigned TagLen = ARRAY_LATENCY + COLS;

  localparam logic [1:0] StIdle  = 2'd0;
  localparam logic [1:0] StRun   = 2'd1;
  localparam logic [1:0] StDrain = 2'd2;
  localparam logic [1:0] StDone  = 2'd3;

  logic [1:0]       state_q, state_d;
  logic [CNT_W-1:0] n_q, n_d;
  logic [CNT_W-1:0] acc_cnt_q, acc_cnt_d;
  logic [CNT_W-1:0] out_cnt_q, out_cnt_d;
  logic             accept;

  assign in_ready_o = (state_q == StRun) && (acc_cnt_q < n_q);
  assign accept     = in_valid_i && in_ready_o;
  assign busy_o     = (state_q != StIdle);
  assign done_o     = (state_q == StDone);

  always_comb begin
    state_d   = state_q;
    n_d       = n_q;
    acc_cnt_d = acc_cnt_q;
    out_cnt_d = out_cnt_q;
    if (accept) acc_cnt_d = acc_cnt_q + 1'b1;
    if (out_valid_o && (out_cnt_q < n_q)) out_cnt_d = out_cnt_q + 1'b1;
    case (state_q)
      StIdle: begin
        if (start_i) begin
          n_d       = num_vectors_i;
          acc_cnt_d = '0;
          out_cnt_d = '0;
          state_d   = (num_vectors_i == '0) ? StDone : StRun;
        end
      end
      StRun:   if (accept && (acc_cnt_d == n_q)) state_d = StDrain;
      StDrain: if (out_cnt_d == n_q) state_d = StDone;
      StDone:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
    if (abort_i) begin
      state_d   = StIdle;
      acc_cnt_d = '0;
      out_cnt_d = '0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= StIdle;
      n_q       <= '0;
      acc_cnt_q <= '0;
      out_cnt_q <= '0;
    end else begin
      state_q   <= state_d;
      n_q       <= n_d;
      acc_cnt_q <= acc_cnt_d;
      out_cnt_q <= out_cnt_d;
    end
  end

  // Lane i is an (i+1)-deep delay line; bubbles enter as zero data with a clear tag.
  for (genvar i = 0; i < ROWS; i++) begin : g_skew
    logic [i:0][IN_W-1:0] data_q, data_d;
    logic [i:0]           vld_q, vld_d;

    always_comb begin
      data_d    = '0;
      vld_d     = '0;
      data_d[0] = accept ? in_data_i[i*IN_W +: IN_W] : '0;
      vld_d[0]  = accept;
      for (int k = 1; k <= i; k++) begin
        data_d[k] = data_q[k-1];
        vld_d[k]  = vld_q[k-1];
      end
      if (abort_i) vld_d = '0;
    end

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        data_q <= '0;
        vld_q  <= '0;
      end else begin
        data_q <= data_d;
        vld_q  <= vld_d;
      end
    end

    assign a_o[i*IN_W +: IN_W] = vld_q[i] ? data_q[i] : '0;
    assign a_valid_o[i]        = vld_q[i];
  end

  logic [COLS*OUT_W-1:0] aligned;

  for (genvar j = 0; j < COLS; j++) begin : g_deskew
    if (j == COLS - 1) begin : g_direct
      assign aligned[j*OUT_W +: OUT_W] = res_i[j*OUT_W +: OUT_W];
    end else begin : g_delay
      localparam int unsigned Depth = COLS - 1 - j;
      logic [Depth-1:0][OUT_W-1:0] dly_q, dly_d;

      always_comb begin
        dly_d    = '0;
        dly_d[0] = res_i[j*OUT_W +: OUT_W];
        for (int k = 1; k < Depth; k++) dly_d[k] = dly_q[k-1];
      end

      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) dly_q <= '0;
        else        dly_q <= dly_d;
      end

      assign aligned[j*OUT_W +: OUT_W] = dly_q[Depth-1];
    end
  end

  logic [TagLen-1:0]     tag_q, tag_d;
  logic                  out_valid_q, out_valid_d;
  logic [COLS*OUT_W-1:0] out_data_q, out_data_d;

  always_comb begin
    tag_d       = {tag_q[TagLen-2:0], accept};
    out_valid_d = tag_q[TagLen-1];
    out_data_d  = tag_q[TagLen-1] ? aligned : out_data_q;
    if (abort_i) begin
      tag_d       = '0;
      out_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tag_q       <= '0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
    end else begin
      tag_q       <= tag_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
    end
  end

  assign out_valid_o = out_valid_q;
  assign out_data_o  = out_data_q;

endmodule

// File: doc/hs_npu_mm_stream_ctrl.md
Name: hs_npu_mm_stream_ctrl

Overview:
- Self-sequencing skew/deskew controller for the NPU matrix-multiply datapath, with independent row and column counts.
- Accepts input vectors over a valid/ready handshake and skews them diagonally into the systolic array.
- Re-aligns the array's diagonally skewed results into full output vectors.
- Replaces the external start pulses and enable-cycle programming with an internal FSM. Supports a programmable vector count and input bubbles.

Parameters:
- ROWS, 8, number of array input lanes (K dimension), ≥1.
- COLS, 8, number of array output lanes (N dimension), ≥1.
- IN_W, 16, input element width.
- OUT_W, 32, result element width.
- ARRAY_LATENCY, 8, cycles from lane-0 input to result lane 0, ≥1.
- CNT_W, 16, width of the vector counters.

Ports:
- clk  in  1  core clock
- rst_n  in  1  reset, asynchronous and active-low
- start_i  in  1  begin a job; sampled only in IDLE
- abort_i  in  1  synchronous flush to IDLE
- num_vectors_i  in  CNT_W  vectors in the job; latched on start
- in_data_i  in  ROWS×IN_W  input vector
- in_valid_i  in  1  input vector valid
- in_ready_o  out  1  controller accepts a vector
- a_o  out  ROWS×IN_W  skewed data to array, lane i
- a_valid_o  out  ROWS  per-lane element valid
- res_i  in  COLS×OUT_W  skewed results from array
- out_data_o  out  COLS×OUT_W  deskewed result vector
- out_valid_o  out  1  out_data_o holds a complete vector
- busy_o  out  1  state ≠ IDLE
- done_o  out  1  one-cycle job-complete pulse

Behaviour:
- Reset values: all outputs 0; all skew/deskew registers and valid tags 0; both counters 0; state IDLE.

FSM states: IDLE, RUN, DRAIN, DONE.
- IDLE → RUN when start_i=1. This latches num_vectors_i into N and clears acc_cnt and out_cnt.
- If the latched N=0, IDLE → DONE instead.
- RUN → DRAIN in the cycle acc_cnt reaches N after an accept.
- DRAIN → DONE on the cycle out_cnt reaches N.
- DONE → IDLE unconditionally. done_o=1 only in DONE.
- start_i is ignored outside IDLE.
- abort_i overrides everything: next state IDLE, all valid tags cleared, counters cleared, no done_o. Data registers may keep stale values; only their valid tags matter.

Input handshake:
- in_ready_o = (state==RUN) && (acc_cnt < N). It is combinational from state and counter only, never from in_valid_i.
- An accept is in_valid_i && in_ready_o. It increments acc_cnt.
- A cycle with no accept (a bubble) injects zeros with valid tag 0. Bubbles are allowed any number of times.

Input skew:
- A vector accepted in cycle t presents element i on a_o[i] during cycle t+1+i, with a_valid_o[i]=1.
- Lane i is a registered delay line of depth i+1 carrying data and a valid tag.
- Lanes carrying no valid element output 0.

Output tag pipeline:
- The accept bit travels through a shift register of length ARRAY_LATENCY+COLS+1.
- The array is not stalled and there is no output backpressure.

Deskew:
- For the vector accepted at t, res_i[j] is sampled during cycle t+1+ARRAY_LATENCY+j.
- Lane j is delayed by COLS-1-j cycles, then all lanes pass through one common output register.
- out_data_o/out_valid_o are therefore presented in cycle t+1+ARRAY_LATENCY+COLS. Total latency from accept = ARRAY_LATENCY+COLS+1 cycles.
- out_data_o holds its last value when out_valid_o=0.
- Each out_valid_o increments out_cnt.

Ordering and counters:
- Output vectors appear in accept order.
- Bubbles in the input reproduce as bubbles in out_valid_o at the same spacing.
- out_cnt never exceeds N, and no out_valid_o occurs in IDLE.
- Back-to-back jobs are allowed: start_i may be accepted the cycle after DONE, which is the first IDLE cycle.

Widths and boundaries:
- Counter comparisons are unsigned and counters saturate at N.
- N = 2^CNT_W − 1 is legal.
- ROWS=1 or COLS=1 degenerates to zero added skew on that side.

Test Plan:
- ROWS=4, COLS=3, ARRAY_LATENCY=5; N=1; accept vector [1,2,3,4] at cycle 10:
  - a_o[0]=1 @11, a_o[1]=2 @12, a_o[2]=3 @13, a_o[3]=4 @14.
  - Drive res lane j with 100+j at cycle 16+j → out_data_o=[100,101,102] with out_valid_o @19.
  - done_o @20; busy_o low @21.
- N=5, in_valid_i held high: exactly 5 accepts; in_ready_o drops after the 5th; 5 consecutive out_valid_o pulses; done_o one cycle after the last.
- N=4 with in_valid_i pattern 1,0,0,1,1,0,1: out_valid_o shows the same 1,0,0,1,1,0,1 spacing; a_valid_o is 0 for bubble slots.
- num_vectors_i=0 with start: busy_o=1 for 1 cycle (DONE), done_o pulses, in_ready_o and out_valid_o never assert.
- abort_i asserted mid-DRAIN with 2 vectors in flight: next cycle IDLE, no further out_valid_o, no done_o. A new start with N=1 completes normally.
- Async reset asserted mid-RUN: all outputs 0 immediately, without waiting for a clock edge. After release, start_i during a non-IDLE state is ignored and a normal job completes.
